// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: walks one 1-bit slice across WIDTH bits, LSB first,
// with registered carry feedback; SLT uses a subtract pass then a less pass.
module serial_alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             s_a,
  output logic             s_b,
  output logic [2:0]       s_op,
  output logic             s_cin,
  output logic             s_lessi,
  input  logic             s_r,
  input  logic             s_cout
);

  typedef enum logic [2:0] {IDLE, RUN, PASS1, PASS2, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q, b_q, sh, res_nx;
  logic [2:0]       op_q;
  logic             set_q;
  logic             active, first, last, arith;

  assign active = (state == RUN) || (state == PASS1) || (state == PASS2);
  assign first  = (cnt == '0);
  assign last   = (cnt == LAST);
  assign arith  = (op_q == 3'b010) || (op_q == 3'b110);
  assign res_nx = {s_r, sh[WIDTH-1:1]};

  always_comb begin
    state_nx = state;
    busy     = active;
    done     = (state == DONE);
    // Operands rotate rather than shift so SLT can walk them twice.
    s_a      = active & a_q[0];
    s_b      = active & b_q[0];
    s_cin    = active & (first ? op_q[2] : carry);
    s_lessi  = (state == PASS2) & first & set_q;
    s_op     = 3'b000;
    case (state)
      IDLE:  if (start) state_nx = (op == 3'b111) ? PASS1 : RUN;
      RUN:   begin s_op = op_q;   if (last) state_nx = DONE;  end
      PASS1: begin s_op = 3'b110; if (last) state_nx = PASS2; end
      PASS2: begin s_op = 3'b111; if (last) state_nx = DONE;  end
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= 3'b000;
      sh     <= '0;
      set_q  <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        a_q   <= a;
        b_q   <= b;
        op_q  <= op;
        cnt   <= '0;
        carry <= 1'b0;
      end else if (active) begin
        a_q   <= {a_q[0], a_q[WIDTH-1:1]};
        b_q   <= {b_q[0], b_q[WIDTH-1:1]};
        carry <= s_cout;
        cnt   <= last ? '0 : cnt + 1'b1;
        sh    <= res_nx;
        // SLT sign: MSB of the difference corrected by its overflow.
        if (last && state == PASS1) set_q <= s_r ^ s_cin ^ s_cout;
        if (last && state != PASS1) begin
          result <= res_nx;
          zero   <= (res_nx == '0);
          ovf    <= (state == RUN) && arith && (s_cin ^ s_cout);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq with a behavioural 1-bit ALU slice attached.
module tb_serial_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        busy, done, zero, ovf;
  logic [31:0] result;
  logic        s_a, s_b, s_cin, s_lessi, s_r, s_cout;
  logic [2:0]  s_op;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_alu_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .result(result), .zero(zero), .ovf(ovf),
    .s_a(s_a), .s_b(s_b), .s_op(s_op), .s_cin(s_cin), .s_lessi(s_lessi),
    .s_r(s_r), .s_cout(s_cout)
  );

  // Slice: op[2] inverts B, op[1:0] selects AND/OR/SUM/LESS.
  logic bb, sum;
  always_comb begin
    bb     = s_b ^ s_op[2];
    sum    = s_a ^ bb ^ s_cin;
    s_cout = (s_a & bb) | (s_a & s_cin) | (bb & s_cin);
    case (s_op[1:0])
      2'b00:   s_r = s_a & bb;
      2'b01:   s_r = s_a | bb;
      2'b10:   s_r = sum;
      default: s_r = s_lessi;
    endcase
  end

  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] iop,
                        input bit midstart, output int lat, output int ndone);
    @(negedge clk);
    a = ia; b = ib; op = iop; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (midstart && lat == 5) begin start = 1'b1; a = 32'h1234_5678; b = 32'h0; op = 3'b010; end
      if (midstart && lat == 6) start = 1'b0;
    end
    ndone = (done === 1'b1) ? 1 : 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({busy, done, zero, ovf} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b want 0000", {busy, done, zero, ovf}); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
    n_cmp++; if ({s_a, s_b, s_op, s_cin, s_lessi} !== 7'b0) begin n_err++; $display("FAIL reset_slice got %b want 0", {s_a, s_b, s_op, s_cin, s_lessi}); end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat, nd;
    run_op(32'd5, 32'd3, 3'b010, 1'b0, lat, nd);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL add_latency got %0d want 33", lat); end
    n_cmp++; if ({result, zero, ovf} !== {32'd8, 1'b0, 1'b0}) begin n_err++; $display("FAIL add_5_3 got %h z%b v%b want 00000008 z0 v0", result, zero, ovf); end
  endtask

  task automatic test_sub();
    int lat, nd;
    run_op(32'd3, 32'd5, 3'b110, 1'b0, lat, nd);
    n_cmp++; if ({result, zero, ovf} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin n_err++; $display("FAIL sub_3_5 got %h z%b v%b want fffffffe z0 v0", result, zero, ovf); end
    run_op(32'd7, 32'd7, 3'b110, 1'b0, lat, nd);
    n_cmp++; if ({result, zero, ovf} !== {32'h0, 1'b1, 1'b0}) begin n_err++; $display("FAIL sub_7_7 got %h z%b v%b want 00000000 z1 v0", result, zero, ovf); end
  endtask

  task automatic test_ovf();
    int lat, nd;
    run_op(32'h7FFF_FFFF, 32'd1, 3'b010, 1'b0, lat, nd);
    n_cmp++; if ({result, ovf} !== {32'h8000_0000, 1'b1}) begin n_err++; $display("FAIL add_ovf got %h v%b want 80000000 v1", result, ovf); end
    run_op(32'h8000_0000, 32'd1, 3'b110, 1'b0, lat, nd);
    n_cmp++; if ({result, ovf} !== {32'h7FFF_FFFF, 1'b1}) begin n_err++; $display("FAIL sub_ovf got %h v%b want 7fffffff v1", result, ovf); end
  endtask

  task automatic test_slt();
    int lat, nd;
    logic [31:0] va [3] = '{32'hFFFF_FFFF, 32'd1, 32'h8000_0000};
    logic [31:0] vb [3] = '{32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] vr [3] = '{32'd1, 32'd0, 32'd1};
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 3'b111, 1'b0, lat, nd);
      n_cmp++; if (lat !== 65) begin n_err++; $display("FAIL slt_latency_%0d got %0d want 65", i, lat); end
      n_cmp++; if ({result, zero, ovf} !== {vr[i], (vr[i] == 0), 1'b0}) begin n_err++; $display("FAIL slt_%0d got %h z%b v%b want %h", i, result, zero, ovf, vr[i]); end
    end
  endtask

  task automatic test_logic();
    int lat, nd;
    run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 1'b1, lat, nd);
    n_cmp++; if (result !== 32'hF000_F000) begin n_err++; $display("FAIL and got %h want f000f000", result); end
    n_cmp++; if (nd !== 1 || lat !== 33) begin n_err++; $display("FAIL and_midstart got %0d dones lat %0d want 1 dones lat 33", nd, lat); end
    run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001, 1'b0, lat, nd);
    n_cmp++; if (result !== 32'hFFF0_FFF0) begin n_err++; $display("FAIL or got %h want fff0fff0", result); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a = 32'd100; b = 32'd23; op = 3'b010; start = 1'b1;
    @(posedge clk); #1;
    a = 32'd40; b = 32'd2;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (result !== 32'd123) begin n_err++; $display("FAIL b2b_first got %h want 0000007b", result); end
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (done !== 1'b1 && lat < 200);
    start = 1'b0;
    n_cmp++; if (lat !== 34 || result !== 32'd42) begin n_err++; $display("FAIL b2b_second got lat %0d res %h want lat 34 res 0000002a", lat, result); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_abort();
    int lat, nd, seen;
    @(negedge clk);
    a = 32'd9; b = 32'd9; op = 3'b010; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++; if ({busy, done, result} !== {1'b0, 1'b0, 32'h0}) begin n_err++; $display("FAIL abort_state got b%b d%b %h want b0 d0 00000000", busy, done, result); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_done got %0d dones want 0", seen); end
    run_op(32'd1000, 32'd234, 3'b010, 1'b0, lat, nd);
    n_cmp++; if ({result, lat} !== {32'd1234, 32'd33}) begin n_err++; $display("FAIL abort_restart got %h lat %0d want 000004d2 lat 33", result, lat); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ovf();
    test_slt();
    test_logic();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
- Bit-serial sequencer that drives a single 1-bit ALU slice (a, b, op[2:0], cin, lessi → r, cout) over WIDTH cycles. It produces a full WIDTH-bit result from one slice.
- Acts as the initiator side of the slice interface:
  - presents one operand bit pair per cycle, LSB first;
  - feeds the registered carry back into the slice;
  - collects r into a result register.
- Sits between the multi-cycle datapath control and a shared slice instance, as an area-reduced ALU path.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).
- CNT_W, 5, bit-index counter width; must satisfy 2^CNT_W ≥ WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- op  in  3  slice op encoding:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 110 SUB
  - 111 SLT
  - other codes: executed as single pass, slice-defined.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse, result valid.
- result  out  WIDTH  final result; held until the next accepted start.
- zero  out  1  result == 0; valid with done, held.
- ovf  out  1  signed overflow, ADD/SUB only, else 0; held.
- s_a  out  1  operand A bit to slice.
- s_b  out  1  operand B bit to slice.
- s_op  out  3  op to slice.
- s_cin  out  1  carry-in to slice.
- s_lessi  out  1  less input to slice.
- s_r  in  1  slice result bit (combinational from s_* outputs).
- s_cout  in  1  slice carry-out.

Behaviour:
- Reset: synchronous; when rst_n=0 at a clock edge, all state clears.
  - State → IDLE; counter → 0; carry register → 0; captured operands → 0.
  - result=0, zero=0, ovf=0, busy=0, done=0.
  - s_a=s_b=s_cin=s_lessi=0, s_op=000.
  - Reset mid-operation aborts with no done pulse.
- States:
  - IDLE: start=1 captures a, b, op; counter=0.
    - op==111 → PASS1.
    - otherwise → RUN.
    - start=0 → stay.
  - PASS1 (SLT only): drives s_op=110 (subtract) for WIDTH cycles.
    - Result bits are discarded.
    - Records set = (MSB sum) XOR ovf_slt → PASS2, counter=0.
  - PASS2: drives s_op=111 for WIDTH cycles.
    - s_lessi = set at bit 0, 0 at all other bits → DONE.
  - RUN: drives s_op=captured op for WIDTH cycles → DONE.
  - DONE: done=1 for exactly one cycle, busy=0, → IDLE.
- Per-bit cycle, bit i = counter:
  - s_a=A[i], s_b=B[i], s_lessi=0 (except PASS2 bit 0).
  - s_cin = op[2] at i==0, else carry register.
  - At the clock edge: carry register ← s_cout; result shift-in ← s_r; counter increments.
- Pass end: the last bit is i==WIDTH-1; the counter wraps to 0 at the pass end.
- Overflow: ovf = (carry-in to MSB) XOR s_cout at MSB, captured in RUN when op is 010 or 110.
- Zero flag: zero is computed from the final result and registered with done.
- Latency from accepted start to done:
  - single-pass ops: WIDTH+1 cycles;
  - SLT: 2·WIDTH+1 cycles.
- start while busy or in DONE: ignored; not queued.
- start asserted the cycle after done: accepted normally.
- Operand changes after capture: no effect on the current operation.

Test Plan:
- ADD a=5, b=3, WIDTH=32 → done 33 cycles after start; result=8, zero=0, ovf=0.
- SUB a=3, b=5 → result=0xFFFFFFFE, ovf=0. Then SUB a=7, b=7 → result=0, zero=1.
- ADD a=0x7FFFFFFF, b=1 → result=0x80000000, ovf=1. SUB a=0x80000000, b=1 → ovf=1.
- SLT pairs, each with done 65 cycles after start:
  - a=0xFFFFFFFF, b=1 → result=1;
  - a=1, b=0xFFFFFFFF → result=0;
  - a=0x80000000, b=0x7FFFFFFF → result=1 (overflow-corrected).
- AND/OR with a=0xF0F0F0F0, b=0xFF00FF00:
  - AND → 0xF000F000;
  - OR → 0xFFF0FFF0.
  - Additionally, assert start mid-run → ignored, and a single done pulse is seen.
- rst_n=0 at bit 10 of an ADD → next cycle busy=0, result=0, no done. A new ADD started afterwards completes correctly.
